// File: rtl/scu_int_ctrl_pkg.sv
// Shared types, register masks and the interrupt vector/level tables for the SCU interrupt controller.
// Source index 0..13 = internal IST bits, 14..29 = EIS0..15 (IST bits 16..31).
package scu_int_ctrl_pkg;

  typedef logic [31:0] ims_t;
  typedef logic [31:0] ist_t;
  typedef logic        aiack_t;

  localparam ims_t   IMS_WMASK   = 32'h0000_BFFF;
  localparam ims_t   IMS_INIT    = 32'h0000_BFFF;
  localparam ist_t   IST_RMASK   = 32'hFFFF_3FFF;
  localparam ist_t   IST_INIT    = 32'h0000_0000;
  localparam aiack_t AIACK_WMASK = 1'b1;
  localparam aiack_t AIACK_INIT  = 1'b0;

  localparam int N_INT = 14;
  localparam int N_EXT = 16;
  localparam int N_SRC = N_INT + N_EXT;

  localparam logic [7:0] INT_VEC [0:N_SRC-1] = '{
    8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
    8'h4A, 8'h4B, 8'h4C, 8'h4D,
    8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57,
    8'h58, 8'h59, 8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h5E, 8'h5F};

  localparam logic [3:0] INT_LVL [0:N_SRC-1] = '{
    4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8, 4'h8, 4'h6,
    4'h6, 4'h5, 4'h3, 4'h2,
    4'h7, 4'h7, 4'h7, 4'h7, 4'h4, 4'h4, 4'h4, 4'h4,
    4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};

  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_HOLD} int_state_t;

  // IST bit position of a source index (bits 14/15 of IST are unused)
  function automatic logic [4:0] ist_pos(input logic [4:0] idx);
    return (idx < 5'(N_INT)) ? idx : idx + 5'd2;
  endfunction

endpackage

// File: rtl/scu_int_ctrl_prio_enc.sv
// Combinational priority select over the 30 pending sources.
// Highest level wins; on equal level the lower index (lower vector) is kept.
module scu_int_prio_enc
  import scu_int_ctrl_pkg::*;
(
  input  logic [N_SRC-1:0] pend,
  output logic             valid,
  output logic [4:0]       idx,
  output logic [3:0]       level,
  output logic [7:0]       vector
);

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    level  = '0;
    vector = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (pend[i] && (!valid || INT_LVL[i] > level)) begin
        valid  = 1'b1;
        idx    = 5'(i);
        level  = INT_LVL[i];
        vector = INT_VEC[i];
      end
    end
  end

endmodule

// File: rtl/scu_int_ctrl.sv
// SCU interrupt controller: IMS/IST/AIACK registers, source latching and
// IRL/vector presentation to the master SH-2 with acknowledge handling.
module scu_int_ctrl
  import scu_int_ctrl_pkg::*;
#(
  parameter int HOLD_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [13:0] int_src,
  input  logic [15:0] ext_int_n,
  input  logic        ims_wr,
  input  logic        ist_wr,
  input  logic        aiack_wr,
  input  logic [31:0] reg_di,
  output logic [31:0] ist_q,
  output logic        aiack_q,
  output logic [3:0]  irl,
  output logic [7:0]  vec,
  input  logic        iack
);

  // state | meaning
  // IDLE   | nothing presented, waiting for a pending source
  // ASSERT | IRL/VEC driven, tracking the best pending source
  // HOLD   | post-acknowledge gap, IRL forced to 0 for HOLD_CYC CE cycles

  ims_t       ims;
  ist_t       ist, ist_nx, ack_clr, ext_set;
  aiack_t     aiack, aiack_nx;
  int_state_t state, state_nx;
  logic [4:0] cur, cur_nx;
  logic [3:0] irl_nx, cnt, cnt_nx;
  logic [7:0] vec_nx;
  logic       ack_fire;

  logic [N_SRC-1:0] pend;
  logic             sel_valid;
  logic [4:0]       sel_idx;
  logic [3:0]       sel_level;
  logic [7:0]       sel_vector;

  always_comb begin
    pend = '0;
    for (int n = 0; n < N_INT; n++) pend[n] = ist[n] & ~ims[n];
    for (int k = 0; k < N_EXT; k++) pend[N_INT+k] = ist[16+k] & ~ims[15];
  end

  scu_int_prio_enc u_prio (
    .pend   (pend),
    .valid  (sel_valid),
    .idx    (sel_idx),
    .level  (sel_level),
    .vector (sel_vector)
  );

  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    irl_nx   = irl;
    vec_nx   = vec;
    cnt_nx   = cnt;
    ack_fire = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_valid) begin
          state_nx = ST_ASSERT;
          irl_nx   = sel_level;
          vec_nx   = sel_vector;
          cur_nx   = sel_idx;
        end
      end
      ST_ASSERT: begin
        if (iack) begin
          ack_fire = 1'b1;
          irl_nx   = '0;
          vec_nx   = '0;
          cnt_nx   = 4'(HOLD_CYC);
          state_nx = ST_HOLD;
        end else if (!sel_valid) begin
          irl_nx   = '0;
          vec_nx   = '0;
          state_nx = ST_IDLE;
        end else begin
          irl_nx = sel_level;
          vec_nx = sel_vector;
          cur_nx = sel_idx;
        end
      end
      ST_HOLD: begin
        if (cnt <= 4'd1) state_nx = ST_IDLE;
        else cnt_nx = cnt - 4'd1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // New source arrivals are OR'd in last so they survive a clearing write or ack
  always_comb begin
    ack_clr  = ack_fire ? (ist_t'(1) << ist_pos(cur)) : '0;
    ext_set  = aiack ? {~ext_int_n, 16'h0000} : '0;
    ist_nx   = ((ist_wr ? (ist & reg_di) : ist) & ~ack_clr) | {18'h0, int_src} | ext_set;
    aiack_nx = aiack;
    if (aiack_wr) aiack_nx = reg_di[0] & AIACK_WMASK;
    else if (ack_fire && cur >= 5'(N_INT)) aiack_nx = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ims   <= IMS_INIT;
      ist   <= IST_INIT;
      aiack <= AIACK_INIT;
      state <= ST_IDLE;
      cur   <= '0;
      cnt   <= '0;
      irl   <= '0;
      vec   <= '0;
    end else if (ce) begin
      if (ims_wr) ims <= reg_di & IMS_WMASK;
      ist   <= ist_nx;
      aiack <= aiack_nx;
      state <= state_nx;
      cur   <= cur_nx;
      cnt   <= cnt_nx;
      irl   <= irl_nx;
      vec   <= vec_nx;
    end
  end

  assign ist_q   = ist & IST_RMASK;
  assign aiack_q = aiack;

endmodule

// File: tb/tb_scu_int_ctrl.sv
// Bench for scu_int_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the interrupt controller.
module tb_scu_int_ctrl;

  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        rst, ce, ims_wr, ist_wr, aiack_wr, iack;
  logic [13:0] int_src;
  logic [15:0] ext_int_n;
  logic [31:0] reg_di, ist_q;
  logic        aiack_q;
  logic [3:0]  irl;
  logic [7:0]  vec;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  logic [31:0] m_ims, m_ist;
  bit          m_aiack;
  int          m_st;  // 0 idle, 1 presenting, 2 hold gap
  int          m_irl, m_vec, m_cur, m_cnt;
  int          int_lvl_tbl [0:13] = '{15, 14, 13, 12, 11, 10, 9, 8, 8, 6, 6, 5, 3, 2};

  scu_int_ctrl #(.HOLD_CYC(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .int_src   (int_src),
    .ext_int_n (ext_int_n),
    .ims_wr    (ims_wr),
    .ist_wr    (ist_wr),
    .aiack_wr  (aiack_wr),
    .reg_di    (reg_di),
    .ist_q     (ist_q),
    .aiack_q   (aiack_q),
    .irl       (irl),
    .vec       (vec),
    .iack      (iack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lvl_of(input int i);
    if (i < 14) return int_lvl_tbl[i];
    if (i < 18) return 7;
    if (i < 22) return 4;
    return 1;
  endfunction

  function automatic int vec_of(input int i);
    return (i < 14) ? 'h40 + i : 'h50 + (i - 14);
  endfunction

  function automatic int pos_of(input int i);
    return (i < 14) ? i : i + 2;
  endfunction

  task automatic model_step();
    int best;
    int ackb;
    logic [31:0] nist;
    bit pend;
    if (rst) begin
      m_ims = 32'hBFFF; m_ist = 0; m_aiack = 0;
      m_st = 0; m_irl = 0; m_vec = 0; m_cur = 0; m_cnt = 0;
      return;
    end
    if (!ce) return;
    best = -1;
    for (int lv = 15; lv >= 1 && best < 0; lv--)
      for (int i = 0; i < 30 && best < 0; i++) begin
        pend = m_ist[pos_of(i)] && !(i < 14 ? m_ims[i] : m_ims[15]);
        if (pend && lvl_of(i) == lv) best = i;
      end
    ackb = -1;
    case (m_st)
      0: if (best >= 0) begin
           m_st = 1; m_irl = lvl_of(best); m_vec = vec_of(best); m_cur = best;
         end
      1: if (iack) begin
           ackb = m_cur; m_irl = 0; m_vec = 0; m_st = 2; m_cnt = HOLD;
         end else if (best < 0) begin
           m_st = 0; m_irl = 0; m_vec = 0;
         end else begin
           m_irl = lvl_of(best); m_vec = vec_of(best); m_cur = best;
         end
      default: if (m_cnt <= 1) m_st = 0; else m_cnt--;
    endcase
    nist = m_ist;
    if (ist_wr) nist = nist & reg_di;
    if (ackb >= 0) nist[pos_of(ackb)] = 1'b0;
    for (int n = 0; n < 14; n++) if (int_src[n]) nist[n] = 1'b1;
    for (int k = 0; k < 16; k++) if (m_aiack && !ext_int_n[k]) nist[16+k] = 1'b1;
    if (ims_wr) m_ims = reg_di & 32'h0000BFFF;
    if (aiack_wr) m_aiack = reg_di[0];
    else if (ackb >= 14) m_aiack = 0;
    m_ist = nist;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("irl", 32'(irl), 32'(m_irl));
    check("vec", 32'(vec), 32'(m_vec));
    check("ist_q", ist_q, m_ist);
    check("aiack_q", 32'(aiack_q), 32'(m_aiack));
    rst = 0; int_src = '0; ims_wr = 0; ist_wr = 0; aiack_wr = 0; iack = 0; reg_di = '0;
  endtask

  task automatic wr_ims(input logic [31:0] d);
    ims_wr = 1; reg_di = d; cyc();
  endtask

  task automatic clear_all();
    ist_wr = 1; reg_di = 0; cyc();
    repeat (4) cyc();
  endtask

  task automatic wait_irl(input string tag);
    int n = 0;
    while (irl == 0 && n < 20) begin cyc(); n++; end
    check(tag, 32'(irl != 0), 32'd1);
  endtask

  task automatic ack_drain();
    iack = 1; cyc();
    repeat (HOLD + 2) cyc();
  endtask

  initial begin
    rst = 1; ce = 1; int_src = '0; ext_int_n = 16'hFFFF;
    ims_wr = 0; ist_wr = 0; aiack_wr = 0; iack = 0; reg_di = '0;
    cyc();
    check("rst_irl", 32'(irl), 32'd0);
    check("rst_ist", ist_q, 32'd0);

    // 1: VBII unmasked, ack clears it
    wr_ims(32'hBFFE);
    int_src[0] = 1; cyc();
    wait_irl("t1_wait");
    check("t1_irl", 32'(irl), 32'hF);
    check("t1_vec", 32'(vec), 32'h40);
    iack = 1; cyc();
    check("t1_ack_irl", 32'(irl), 32'd0);
    check("t1_ack_ist0", 32'(ist_q[0]), 32'd0);
    repeat (HOLD + 2) cyc();

    // 2: masked T0I latched, then unmasked
    clear_all();
    wr_ims(32'hBFFF);
    int_src[3] = 1; cyc();
    repeat (3) cyc();
    check("t2_ist3", 32'(ist_q[3]), 32'd1);
    check("t2_irl_masked", 32'(irl), 32'd0);
    wr_ims(32'hBFF7);
    wait_irl("t2_wait");
    check("t2_irl", 32'(irl), 32'hC);
    check("t2_vec", 32'(vec), 32'h43);
    ack_drain();

    // 3: SMI and PADI share level 8, lower vector first
    clear_all();
    wr_ims(32'hBE7F);
    int_src[7] = 1; int_src[8] = 1; cyc();
    wait_irl("t3_wait1");
    check("t3_vec1", 32'(vec), 32'h47);
    iack = 1; cyc();
    wait_irl("t3_wait2");
    check("t3_vec2", 32'(vec), 32'h48);
    ack_drain();

    // 4: VBII preempts D0EI
    clear_all();
    wr_ims(32'hB7FE);
    int_src[11] = 1; cyc();
    wait_irl("t4_wait");
    check("t4_irl_d0ei", 32'(irl), 32'h5);
    int_src[0] = 1; cyc();
    cyc();
    check("t4_irl_vbii", 32'(irl), 32'hF);
    check("t4_vec_vbii", 32'(vec), 32'h40);
    iack = 1; cyc();
    check("t4_ist11_kept", 32'(ist_q[11]), 32'd1);
    check("t4_ist0_clr", 32'(ist_q[0]), 32'd0);
    wait_irl("t4_wait2");
    ack_drain();

    // 5: external gating through AIACK
    clear_all();
    wr_ims(32'h3FFF);
    aiack_wr = 1; reg_di = 1; cyc();
    ext_int_n[2] = 0; cyc();
    ext_int_n[2] = 1;
    wait_irl("t5_wait");
    check("t5_irl", 32'(irl), 32'h7);
    check("t5_vec", 32'(vec), 32'h52);
    iack = 1; cyc();
    check("t5_aiack_clr", 32'(aiack_q), 32'd0);
    ext_int_n[5] = 0;
    repeat (4) cyc();
    check("t5_ext5_ignored", 32'(ist_q[21]), 32'd0);
    aiack_wr = 1; reg_di = 1; cyc();
    cyc();
    check("t5_ext5_latched", 32'(ist_q[21]), 32'd1);
    ext_int_n[5] = 1;
    wait_irl("t5_wait2");
    check("t5_vec2", 32'(vec), 32'h55);
    ack_drain();

    // 6: set beats clearing write; reset during HOLD
    clear_all();
    wr_ims(32'hBFFF);
    int_src[0] = 1; ist_wr = 1; reg_di = 32'hFFFFFFFE; cyc();
    check("t6_set_wins", 32'(ist_q[0]), 32'd1);
    wr_ims(32'hBFFE);
    wait_irl("t6_wait");
    iack = 1; cyc();
    rst = 1; cyc();
    check("t6_rst_irl", 32'(irl), 32'd0);
    check("t6_rst_ist", ist_q, 32'd0);
    int_src[0] = 1; cyc();
    repeat (3) cyc();
    check("t6_ims_reset", 32'(irl), 32'd0);

    // randomized traffic
    for (int t = 0; t < 3000; t++) begin
      ce = ($urandom_range(0, 9) != 0);
      int_src = 14'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 9) == 0)
        ext_int_n = ($urandom_range(0, 1) == 0) ? 16'hFFFF : ~(16'd1 << $urandom_range(0, 15));
      if ($urandom_range(0, 14) == 0) begin ims_wr = 1; reg_di = $urandom & $urandom; end
      else if ($urandom_range(0, 14) == 0) begin ist_wr = 1; reg_di = ~($urandom & $urandom); end
      else if ($urandom_range(0, 11) == 0) begin aiack_wr = 1; reg_di = $urandom; end
      iack = (m_st == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
